counter_mod: RTL and testbench



---
 rtl/counter_mod.sv | 97 +++++++++
 tb/tb_counter_mod.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod.sv
// Programmable up/down counter with limit, step, wrap/saturate selection,
// registered terminal-count pulse and sticky overflow for multiplier sequencing.
module counter_mod #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] data_in,
    input  logic         en,
    input  logic         up_down,
    input  logic [N-1:0] step,
    input  logic [N-1:0] limit,
    input  logic         wrap_mode,
    output logic [N-1:0] data_out,
    output logic         end_flag,
    output logic         at_limit,
    output logic         tc_pulse,
    output logic         overflow
);

    logic [N-1:0] count_reg, count_next;
    logic         tc_reg, tc_next;
    logic         ovf_reg, ovf_next;

    logic [N:0]   sum_up;
    logic [N-1:0] diff_down;
    logic         stale;
    logic         overshoot;
    logic         boundary;

    // The extra bit keeps count + step from aliasing back into range.
    assign sum_up    = {1'b0, count_reg} + {1'b0, step};
    assign diff_down = count_reg - step;
    assign stale     = (count_reg > limit);

    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        ovf_next   = ovf_reg;
        overshoot  = 1'b0;
        boundary   = 1'b0;
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (load) begin
            count_next = (data_in > limit) ? limit : data_in;
            ovf_next   = 1'b0;
        end else if (en && (step != '0)) begin
            if (up_down) begin
                if (stale || (sum_up > {1'b0, limit})) begin
                    overshoot  = 1'b1;
                    count_next = wrap_mode ? '0 : limit;
                end else begin
                    count_next = sum_up[N-1:0];
                    boundary   = (sum_up[N-1:0] == limit);
                end
            end else begin
                // A count left above a lowered limit always lands on the limit when counting down.
                if (stale) begin
                    overshoot  = 1'b1;
                    count_next = limit;
                end else if (count_reg < step) begin
                    overshoot  = 1'b1;
                    count_next = wrap_mode ? limit : '0;
                end else begin
                    count_next = diff_down;
                    boundary   = (diff_down == '0);
                end
            end
            tc_next = boundary | overshoot;
            if (overshoot) begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign data_out = count_reg;
    assign tc_pulse = tc_reg;
    assign overflow = ovf_reg;
    assign end_flag = (count_reg == '0);
    assign at_limit = (count_reg == limit);

endmodule

// File: tb/tb_counter_mod.sv
// Table-driven scoreboard bench for counter_mod (N=8): vectors push expected
// results when driven, and they are popped and compared one cycle later.
module tb_counter_mod;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         load;
    logic [N-1:0] data_in;
    logic         en;
    logic         up_down;
    logic [N-1:0] step;
    logic [N-1:0] limit;
    logic         wrap_mode;
    logic [N-1:0] data_out;
    logic         end_flag;
    logic         at_limit;
    logic         tc_pulse;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        logic         clr;
        logic         load;
        logic         en;
        logic         up_down;
        logic         wrap;
        logic [N-1:0] data_in;
        logic [N-1:0] step;
        logic [N-1:0] limit;
        logic [N-1:0] exp_data;
        logic         exp_tc;
        logic         exp_ovf;
    } vec_t;

    typedef struct {
        string        name;
        logic [N-1:0] data;
        logic         tc;
        logic         ovf;
        logic [N-1:0] limit;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    counter_mod #(.N(N)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .data_in(data_in),
        .en(en), .up_down(up_down), .step(step), .limit(limit),
        .wrap_mode(wrap_mode), .data_out(data_out), .end_flag(end_flag),
        .at_limit(at_limit), .tc_pulse(tc_pulse), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0d required=%0d", name, what, act, req);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk(e.name, "data_out", 32'(data_out), 32'(e.data));
        chk(e.name, "tc_pulse", 32'(tc_pulse), 32'(e.tc));
        chk(e.name, "overflow", 32'(overflow), 32'(e.ovf));
        chk(e.name, "end_flag", 32'(end_flag), 32'(e.data == '0));
        chk(e.name, "at_limit", 32'(at_limit), 32'(e.data == e.limit));
        $display("txn %-14s in: clr=%0b load=%0b en=%0b ud=%0b wrap=%0b din=%0d step=%0d lim=%0d | out=%0d tc=%0b ovf=%0b",
                 e.name, clr, load, en, up_down, wrap_mode, data_in, step, limit,
                 data_out, tc_pulse, overflow);
    endtask

    // Drive one vector, push its expectation, then pop and compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        clr       = v.clr;
        load      = v.load;
        en        = v.en;
        up_down   = v.up_down;
        wrap_mode = v.wrap;
        data_in   = v.data_in;
        step      = v.step;
        limit     = v.limit;
        e.name  = v.name;
        e.data  = v.exp_data;
        e.tc    = v.exp_tc;
        e.ovf   = v.exp_ovf;
        e.limit = v.limit;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            check_all(sb_q.pop_front());
        end
    endtask

    function automatic vec_t mk(input string name, input logic c, input logic l, input logic e,
                                input logic ud, input logic w, input int din, input int st,
                                input int lim, input int xd, input logic xt, input logic xo);
        vec_t v;
        v.name = name; v.clr = c; v.load = l; v.en = e; v.up_down = ud; v.wrap = w;
        v.data_in = N'(din); v.step = N'(st); v.limit = N'(lim);
        v.exp_data = N'(xd); v.exp_tc = xt; v.exp_ovf = xo;
        return v;
    endfunction

    initial begin
        exp_t e;

        // Up / saturate, limit 10 step 3
        vecs.push_back(mk("up_sat_3",   0,0,1,1,0,  0,3,10,  3,0,0));
        vecs.push_back(mk("up_sat_6",   0,0,1,1,0,  0,3,10,  6,0,0));
        vecs.push_back(mk("up_sat_9",   0,0,1,1,0,  0,3,10,  9,0,0));
        vecs.push_back(mk("up_sat_10a", 0,0,1,1,0,  0,3,10, 10,1,1));
        vecs.push_back(mk("up_sat_10b", 0,0,1,1,0,  0,3,10, 10,1,1));
        vecs.push_back(mk("clr",        1,0,0,1,0,  0,3,10,  0,0,0));
        // Up / wrap exact, limit 9 step 3
        vecs.push_back(mk("up_wrap_3",  0,0,1,1,1,  0,3,9,   3,0,0));
        vecs.push_back(mk("up_wrap_6",  0,0,1,1,1,  0,3,9,   6,0,0));
        vecs.push_back(mk("up_wrap_9",  0,0,1,1,1,  0,3,9,   9,1,0));
        vecs.push_back(mk("up_wrap_0",  0,0,1,1,1,  0,3,9,   0,1,1));
        vecs.push_back(mk("up_wrap_3b", 0,0,1,1,1,  0,3,9,   3,0,1));
        // Down / wrap, limit 20 step 2
        vecs.push_back(mk("load5",      0,1,0,0,1,  5,2,20,  5,0,0));
        vecs.push_back(mk("dn_wrap_3",  0,0,1,0,1,  0,2,20,  3,0,0));
        vecs.push_back(mk("dn_wrap_1",  0,0,1,0,1,  0,2,20,  1,0,0));
        vecs.push_back(mk("dn_wrap_20", 0,0,1,0,1,  0,2,20, 20,1,1));
        vecs.push_back(mk("dn_wrap_18", 0,0,1,0,1,  0,2,20, 18,0,1));
        vecs.push_back(mk("load50_clmp",0,1,0,0,1, 50,2,20, 20,0,0));
        // Priority
        vecs.push_back(mk("load7",      0,1,0,1,0,  7,2,20,  7,0,0));
        vecs.push_back(mk("clr_ld_en",  1,1,1,1,0,  4,2,20,  0,0,0));
        vecs.push_back(mk("ld_over_en", 0,1,1,1,0,  4,2,20,  4,0,0));
        vecs.push_back(mk("dn_exact_2", 0,0,1,0,0,  0,2,20,  2,0,0));
        vecs.push_back(mk("dn_exact_0", 0,0,1,0,0,  0,2,20,  0,1,0));
        vecs.push_back(mk("step0_hold", 0,0,1,1,0,  0,0,20,  0,0,0));
        vecs.push_back(mk("step0_dn",   0,0,1,0,0,  0,0,20,  0,0,0));
        vecs.push_back(mk("dn_sat_0",   0,0,1,0,0,  0,1,20,  0,1,1));
        vecs.push_back(mk("idle_hold",  0,0,0,1,0,  0,1,20,  0,0,1));
        // Stale limit
        vecs.push_back(mk("load200",    0,1,0,0,0,200,1,255,200,0,0));
        vecs.push_back(mk("stale_dnsat",0,0,1,0,0,  0,1,50, 50,1,1));
        vecs.push_back(mk("load200b",   0,1,0,1,1,200,1,255,200,0,0));
        vecs.push_back(mk("stale_upwrp",0,0,1,1,1,  0,1,50,  0,1,1));
        // Full-width arithmetic
        vecs.push_back(mk("load255",    0,1,0,1,1,255,255,255,255,0,0));
        vecs.push_back(mk("w255_wrap",  0,0,1,1,1,  0,255,255, 0,1,1));
        vecs.push_back(mk("load255b",   0,1,0,1,0,255,255,255,255,0,0));
        vecs.push_back(mk("w255_sat",   0,0,1,1,0,  0,255,255,255,1,1));

        rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up_down = 1'b1;
        wrap_mode = 1'b0; data_in = '0; step = '0; limit = 8'd5;
        repeat (2) @(posedge clk);
        #1;
        e.name = "reset"; e.data = '0; e.tc = 1'b0; e.ovf = 1'b0; e.limit = 8'd5;
        check_all(e);
        limit = '0;
        #1;
        e.name = "reset_lim0"; e.limit = '0;
        check_all(e);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset mid-count with tc and overflow both set.
        apply(mk("load37",  0,1,0,1,0, 37,1,37, 37,0,0));
        apply(mk("sat37",   0,0,1,1,0,  0,1,37, 37,1,1));
        #2;
        rst = 1'b0;
        #1;
        e.name = "async_rst"; e.data = '0; e.tc = 1'b0; e.ovf = 1'b0; e.limit = 8'd37;
        check_all(e);
        @(posedge clk);
        #1;
        e.name = "rst_held";
        check_all(e);
        rst = 1'b1;
        apply(mk("resume_1", 0,0,1,1,0, 0,1,100, 1,0,0));
        apply(mk("resume_2", 0,0,1,1,0, 0,1,100, 2,0,0));

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
